mem_stage_sram_ctrl: RTL and testbench

Memory-stage consumer of the EX/MEM pipeline register. It takes the registered memory-read/write enables, ALU result (address) and Rm value (store data) and performs one 32-bit word access on an external 16-bit asynchronous SRAM as two halfword phases. While an access is in progress it drops `ready`, which freezes the upstream pipeline. It returns the loaded word on `readData` to the MEM/WB register.

---
 rtl/mem_stage_sram_ctrl_if.sv | 27 ++
 rtl/mem_stage_sram_ctrl.sv | 121 ++++++++++++
 tb/tb_mem_stage_sram_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_sram_ctrl_if.sv
// Halfword SRAM pin bundle between the memory-stage controller (master) and the SRAM (slave).
`timescale 1ns / 1ps
interface mem_stage_sram_ctrl_if #(
   parameter int unsigned ADDR_W = 18
);
   logic [ADDR_W-1:0] sramAddress;
   logic [15:0]       sramDataOut;
   logic              sramDataOutEnable;
   logic              sramWriteEnableN;
   logic [15:0]       sramDataIn;

   modport master (
      output sramAddress,
      output sramDataOut,
      output sramDataOutEnable,
      output sramWriteEnableN,
      input  sramDataIn
   );

   modport slave (
      input  sramAddress,
      input  sramDataOut,
      input  sramDataOutEnable,
      input  sramWriteEnableN,
      output sramDataIn
   );
endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage controller: one 32-bit load/store as two halfword phases on a 16-bit async SRAM.
// Optional SRAM_ADDR_CHECK_EN discards out-of-range accesses in IDLE.
`timescale 1ns / 1ps
module mem_stage_sram_ctrl #(
   parameter int unsigned WAIT_CYCLES = 2,
   parameter int unsigned SRAM_WORDS  = 131072,
   parameter int unsigned ADDR_W      = 18
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         memoryReadEnabledIn,
   input  logic                         memoryWriteEnabledIn,
   input  logic [31:0]                  aluResultIn,
   input  logic [31:0]                  valRmIn,
   output logic                         ready,
   output logic [31:0]                  readData,
   mem_stage_sram_ctrl_if.master        sram
);

   typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

   localparam logic [3:0]        LastCnt  = 4'(WAIT_CYCLES - 1);
   localparam logic [ADDR_W-2:0] WordMask = (ADDR_W - 1)'(SRAM_WORDS - 1);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] read_data_q, read_data_d;

   logic              req, is_write, is_read, last, addr_ok;
   logic [31:0]       offset;
   logic [ADDR_W-2:0] word_idx;
   logic              unused_offset;

   assign req      = memoryReadEnabledIn | memoryWriteEnabledIn;
   assign is_write = memoryWriteEnabledIn;
   assign is_read  = memoryReadEnabledIn & ~memoryWriteEnabledIn;
   assign last     = (cnt_q == LastCnt);

   assign offset        = aluResultIn - 32'd1024;
   assign word_idx      = offset[ADDR_W:2] & WordMask;
   assign unused_offset = ^{offset[31:ADDR_W+1], offset[1:0]};

`ifdef SRAM_ADDR_CHECK_EN
   localparam longint unsigned AddrLimit = 64'd1024 + 64'd4 * 64'(SRAM_WORDS);
   assign addr_ok = (aluResultIn >= 32'd1024) && ({32'd0, aluResultIn} < AddrLimit);
`else
   assign addr_ok = 1'b1;
`endif

   assign readData = read_data_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         read_data_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         read_data_q <= read_data_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = '0;
      read_data_d = read_data_q;
      case (state_q)
         StIdle: begin
            if (req && addr_ok) state_d = StLow;
            if (is_read && !addr_ok) read_data_d = '0;
         end
         StLow: begin
            if (last) begin
               state_d = StHigh;
               if (is_read) read_data_d[15:0] = sram.sramDataIn;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         StHigh: begin
            if (last) begin
               state_d = StDone;
               if (is_read) read_data_d[31:16] = sram.sramDataIn;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Reset forces idle pin values at once so an aborted store stops strobing immediately.
   always_comb begin
      ready                  = 1'b0;
      sram.sramAddress       = '0;
      sram.sramDataOut       = '0;
      sram.sramDataOutEnable = 1'b0;
      sram.sramWriteEnableN  = 1'b1;
      if (rst) begin
         ready = 1'b1;
      end else begin
         case (state_q)
            StIdle: ready = !(req && addr_ok);
            StLow, StHigh: begin
               sram.sramAddress = {word_idx, state_q == StHigh};
               if (is_write) begin
                  sram.sramDataOutEnable = 1'b1;
                  sram.sramDataOut       = (state_q == StHigh) ? valRmIn[31:16] : valRmIn[15:0];
                  // Strobe rises on the last count so address and data are held past it.
                  sram.sramWriteEnableN  = last;
               end
            end
            StDone:  ready = 1'b1;
            default: ready = 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl with a behavioural 16-bit SRAM on the interface.
`timescale 1ns / 1ps
module tb_mem_stage_sram_ctrl;
   localparam int unsigned W = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rd_en = 1'b0;
   logic        wr_en = 1'b0;
   logic [31:0] alu = 32'd0;
   logic [31:0] rm = 32'd0;
   logic        ready;
   logic [31:0] rdata;
   int          total = 0;
   int          bad = 0;

   logic [15:0] mem [0:262143];

   mem_stage_sram_ctrl_if #(.ADDR_W(18)) sif ();

   mem_stage_sram_ctrl #(
      .WAIT_CYCLES(W),
      .SRAM_WORDS(131072),
      .ADDR_W(18)
   ) dut (
      .clk(clk),
      .rst(rst),
      .memoryReadEnabledIn(rd_en),
      .memoryWriteEnabledIn(wr_en),
      .aluResultIn(alu),
      .valRmIn(rm),
      .ready(ready),
      .readData(rdata),
      .sram(sif)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (sif.sramDataOutEnable && !sif.sramWriteEnableN) mem[sif.sramAddress] <= sif.sramDataOut;
   end
   assign sif.sramDataIn = mem[sif.sramAddress];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_pins(input string tag);
      chk({tag, ".addr"}, 32'(sif.sramAddress), 32'd0);
      chk({tag, ".dout"}, 32'(sif.sramDataOut), 32'd0);
      chk({tag, ".oe"}, 32'(sif.sramDataOutEnable), 32'd0);
      chk({tag, ".we_n"}, 32'(sif.sramWriteEnableN), 32'd1);
   endtask

   // Called mid-cycle while the DUT is in IDLE; returns mid-cycle in DONE with requests dropped.
   task automatic access(input string tag, input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [17:0] hw_lo,
                         input logic [31:0] exp_rdata);
      rd_en = rd;
      wr_en = wr;
      alu   = addr;
      rm    = wdata;
      #1;
      chk({tag, ".req_ready"}, 32'(ready), 32'd0);
      for (int ph = 0; ph < 2; ph++) begin
         for (int c = 0; c < int'(W); c++) begin
            @(negedge clk);
            chk($sformatf("%s.p%0d.c%0d.ready", tag, ph, c), 32'(ready), 32'd0);
            chk($sformatf("%s.p%0d.c%0d.addr", tag, ph, c), 32'(sif.sramAddress),
                32'(hw_lo + 18'(ph)));
            chk($sformatf("%s.p%0d.c%0d.oe", tag, ph, c), 32'(sif.sramDataOutEnable), 32'(wr));
            chk($sformatf("%s.p%0d.c%0d.we_n", tag, ph, c), 32'(sif.sramWriteEnableN),
                (wr && c != int'(W) - 1) ? 32'd0 : 32'd1);
            if (wr) begin
               chk($sformatf("%s.p%0d.c%0d.dout", tag, ph, c), 32'(sif.sramDataOut),
                   (ph == 1) ? 32'(wdata[31:16]) : 32'(wdata[15:0]));
            end
         end
      end
      @(negedge clk);
      chk({tag, ".done_ready"}, 32'(ready), 32'd1);
      chk_idle_pins({tag, ".done"});
      chk({tag, ".done_rdata"}, rdata, exp_rdata);
      rd_en = 1'b0;
      wr_en = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(ready), 32'd1);
      rst = 1'b0;
      #1;
      chk("reset.ready", 32'(ready), 32'd1);
      chk("reset.rdata", rdata, 32'd0);
      chk_idle_pins("reset");

      access("wr0", 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 18'd0, 32'd0);
      chk("wr0.mem0", 32'(mem[0]), 32'h0000BEEF);
      chk("wr0.mem1", 32'(mem[1]), 32'h0000DEAD);
      @(negedge clk);
      chk("wr0.idle_ready", 32'(ready), 32'd1);

      access("wr1", 1'b0, 1'b1, 32'd1028, 32'h12345678, 18'd2, 32'd0);
      @(negedge clk);
      access("rd1", 1'b1, 1'b0, 32'd1028, 32'd0, 18'd2, 32'h12345678);
      @(negedge clk);

      access("rw", 1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, 18'd4, 32'h12345678);
      chk("rw.mem4", 32'(mem[4]), 32'h0000F00D);
      chk("rw.mem5", 32'(mem[5]), 32'h0000CAFE);
      @(negedge clk);

      access("b2b0", 1'b1, 1'b0, 32'd1024, 32'd0, 18'd0, 32'hDEADBEEF);
      @(negedge clk);
      chk("b2b.gap_ready", 32'(ready), 32'd1);
      access("b2b1", 1'b1, 1'b0, 32'd1028, 32'd0, 18'd2, 32'h12345678);

      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("nomem%0d.ready", i), 32'(ready), 32'd1);
         chk($sformatf("nomem%0d.we_n", i), 32'(sif.sramWriteEnableN), 32'd1);
      end

`ifdef SRAM_ADDR_CHECK_EN
      rd_en = 1'b1;
      alu   = 32'd512;
      #1;
      chk("chk512.req_ready", 32'(ready), 32'd1);
      chk("chk512.we_n", 32'(sif.sramWriteEnableN), 32'd1);
      @(negedge clk);
      chk("chk512.ready", 32'(ready), 32'd1);
      chk_idle_pins("chk512");
      chk("chk512.rdata", rdata, 32'd0);
      rd_en = 1'b0;
      @(negedge clk);
`else
      access("wrap", 1'b0, 1'b1, 32'd525312, 32'h0BADF00D, 18'd0, 32'h12345678);
      chk("wrap.mem0", 32'(mem[0]), 32'h0000F00D);
      chk("wrap.mem1", 32'(mem[1]), 32'h00000BAD);
      @(negedge clk);
      access("rdwrap", 1'b1, 1'b0, 32'd1024, 32'd0, 18'd0, 32'h0BADF00D);
      @(negedge clk);
`endif

      // Abort a store in its second LOW cycle.
      wr_en = 1'b1;
      alu   = 32'd1040;
      rm    = 32'h11112222;
      #1;
      @(negedge clk);
      @(negedge clk);
      chk("abort.low1_we_n", 32'(sif.sramWriteEnableN), 32'd1);
      rst   = 1'b1;
      wr_en = 1'b0;
      #1;
      chk("abort.rst_ready", 32'(ready), 32'd1);
      chk("abort.rst_we_n", 32'(sif.sramWriteEnableN), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort.ready", 32'(ready), 32'd1);
      chk("abort.rdata", rdata, 32'd0);
      chk_idle_pins("abort");

      access("post", 1'b1, 1'b0, 32'd1028, 32'd0, 18'd2, 32'h12345678);
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
